seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned non-restoring divider for the hw1 arithmetic datapath. Accepts a WIDTH-bit dividend and divisor over a valid/ready handshake and iterates one quotient bit per cycle. Each iteration is a single (WIDTH+1)-bit sign-extended add/subtract step. It returns the quotient and remainder over a second valid/ready handshake. It sits downstream of the add/subtract unit as the iterative inverse operation, built from the same add/subtract primitive.

## Interface
- WIDTH, 30, operand width; internal partial remainder is WIDTH+1 bits (sign-extended)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- dividend  in  WIDTH  unsigned dividend
- divisor  in  WIDTH  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  unsigned quotient
- remainder  out  WIDTH  unsigned remainder
- div_zero  out  1  divisor was zero (only driven when DIV_ZERO_DETECT_EN is defined, else constant 0)

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch D=divisor, Q=dividend, R=0 (WIDTH+1 bits), cnt=0, then go to RUN.
- RUN, one iteration per cycle:
  - Shift {R,Q} left by one, so R takes Q's MSB.
  - If the old R sign bit is 0, R=R-D. Otherwise R=R+D. D is zero-extended to WIDTH+1 bits.
  - New Q LSB = ~R[WIDTH].
  - After WIDTH iterations (cnt==WIDTH-1), go to FIX.
- FIX: if R[WIDTH]==1, R=R+D. Go to DONE.
- DONE: out_valid=1. quotient=Q, remainder=R[WIDTH-1:0].
  - On out_valid&out_ready, go to IDLE.
- Operands are accepted only in IDLE (in_ready=0 in RUN/FIX/DONE). There is no overlap of jobs.
- Outputs are registered and stable for the whole DONE state, regardless of input activity.
- Divisor 0 without the detect feature: the natural algorithm yields quotient=all-ones and remainder=dividend. This is the required result.
- All arithmetic is modulo 2^(WIDTH+1) within the step. The carry out of the MSB is discarded.

## Timing
- Reset (asynchronous): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, cnt=0.
- Reset asserted mid-RUN/FIX/DONE aborts the job immediately. No result is produced.
- Latency: out_valid rises WIDTH+1 cycles after the accepting edge (WIDTH RUN cycles plus one FIX cycle). This is 31 for the default.
- Back-pressure: out_valid stays high with outputs held until out_ready. The earliest next accept is the cycle after the output handshake, when in_ready=1.
- A result with out_ready already high completes one cycle after DONE is entered.
- in_valid while busy is ignored; operands are not captured.

## Configuration
- DIV_ZERO_DETECT_EN defined: divisor==0 at accept goes directly IDLE→DONE. out_valid rises the cycle after accept, with quotient=all-ones, remainder=dividend and div_zero=1. div_zero clears on the output handshake or reset.
- Undefined: no shortcut. The full WIDTH+1 latency applies, div_zero is tied 0, and the result values are the same as above.

## Structure
- Shared package: state encoding (IDLE/RUN/FIX/DONE), the default WIDTH constant, and the counter width (clog2 of WIDTH).
- One sub-module, div_addsub_step: combinational (WIDTH+1)-bit add/subtract.
  - Inputs: a, b, sel (1=subtract, via invert-b plus carry-in).
  - Output: sum.
  - It is shared by RUN and FIX (FIX uses sel=0).

## Test plan
- 100 / 7 with out_ready=1: quotient=14, remainder=2; out_valid exactly 31 cycles after accept; in_ready=0 throughout.
- 5 / 9: quotient=0, remainder=5. Then 0x3FFFFFFF / 1: quotient=0x3FFFFFFF, remainder=0. Then 0x3FFFFFFF / 0x3FFFFFFF: quotient=1, remainder=0.
- 1000 / 0:
  - With DIV_ZERO_DETECT_EN: out_valid 1 cycle after accept, div_zero=1, quotient=0x3FFFFFFF, remainder=1000.
  - Without: same values, 31-cycle latency, div_zero=0.
- Back-pressure: run 77 / 3, hold out_ready=0 for 5 cycles after out_valid. quotient=25 and remainder=2 stay stable, in_valid pulses are ignored, and the transfer completes when out_ready rises.
- Reset at iteration 10 of a job: outputs return to reset values asynchronously. A following 50 / 6 returns quotient=8, remainder=2.
- Random 2000 operand pairs: quotient*divisor+remainder==dividend and remainder<divisor for all non-zero divisors.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the seq_divider block: FSM states, default width,
// and iteration-counter sizing.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   localparam int unsigned DIV_WIDTH = 30;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

   // Counter width for an arbitrary operand width, never below one bit.
   function automatic int unsigned div_cnt_width(input int unsigned w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_divider_addsub_step.sv
// Combinational W-bit add/subtract primitive. sel=1 subtracts by inverting b
// and injecting a carry-in. The carry out of the MSB is discarded.
module div_addsub_step #(
   parameter int unsigned W = 31
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] sum
);

   logic [W-1:0] b_eff;

   always_comb begin
      b_eff = b ^ {W{sel}};
      sum   = a + b_eff + W'(sel);
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned non-restoring divider, one quotient bit per cycle.
// Optional divide-by-zero shortcut and flag under DIV_ZERO_DETECT_EN.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned RW    = WIDTH + 1;
   localparam int unsigned CNT_W = div_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [RW-1:0]    r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [RW-1:0]    step_a;
   logic [RW-1:0]    step_b;
   logic             step_sel;
   logic [RW-1:0]    step_sum;

`ifdef DIV_ZERO_DETECT_EN
   logic             dz_q, dz_d;
`endif

   div_addsub_step #(
      .W (RW)
   ) u_step (
      .a   (step_a),
      .b   (step_b),
      .sel (step_sel),
      .sum (step_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
`ifdef DIV_ZERO_DETECT_EN
         dz_q    <= dz_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      r_d      = r_q;
      q_d      = q_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
`ifdef DIV_ZERO_DETECT_EN
      dz_d     = dz_q;
`endif
      // Step operands default to the RUN iteration; FIX overrides them.
      step_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
      step_b   = {1'b0, d_q};
      step_sel = ~r_q[WIDTH];

      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef DIV_ZERO_DETECT_EN
               if (divisor == '0) begin
                  q_d     = '1;
                  r_d     = {1'b0, dividend};
                  dz_d    = 1'b1;
                  state_d = DONE;
               end else begin
                  d_d     = divisor;
                  q_d     = dividend;
                  r_d     = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end
`else
               d_d     = divisor;
               q_d     = dividend;
               r_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
`endif
            end
         end
         RUN: begin
            r_d   = step_sum;
            q_d   = {q_q[WIDTH-2:0], ~step_sum[WIDTH]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = FIX;
            end
         end
         FIX: begin
            step_a   = r_q;
            step_sel = 1'b0;
            if (r_q[WIDTH]) begin
               r_d = step_sum;
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef DIV_ZERO_DETECT_EN
               dz_d    = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = q_q;
   assign remainder = r_q[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
   assign div_zero  = dz_q;
`else
   assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, back-pressure,
// mid-job reset, and randomized jobs against an arithmetic reference model.
module tb_seq_divider;

   localparam int W = 30;
   localparam logic [W-1:0] ONES = 30'h3FFFFFFF;
   localparam int LAT_N = W + 1;
`ifdef DIV_ZERO_DETECT_EN
   localparam int   LAT_Z = 0;
   localparam logic DZ_E  = 1'b1;
`else
   localparam int   LAT_Z = W + 1;
   localparam logic DZ_E  = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   int vectors = 0;
   int miscompares = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
      int           hold;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Latency is counted in clock edges after the accepting edge until
   // out_valid is observed.
   task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          output logic [W-1:0] gq, output logic [W-1:0] gr, output logic gdz,
                          output int lat, output int busy_bad, output int unstable);
      bit done;
      @(negedge clk);
      chk("in_ready before accept", in_ready, 1);
      dividend  = a;
      divisor   = b;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = 0; busy_bad = 0; unstable = 0; done = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         if (out_valid) begin
            done = 1;
         end else begin
            if (in_ready) busy_bad++;
            in_valid = $urandom_range(0, 1) == 1;
            @(posedge clk);
            lat++;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         miscompares++;
         $display("FAIL timeout: out_valid not seen within %0d cycles", lat);
      end
      gq = quotient; gr = remainder; gdz = div_zero;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || quotient !== gq || remainder !== gr || div_zero !== gdz || in_ready)
            unstable++;
         in_valid = (i % 2) == 0;
         dividend = W'($urandom);
         divisor  = W'($urandom);
      end
      if (hold > 0) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid after handshake", out_valid, 0);
      chk("in_ready after handshake", in_ready, 1);
   endtask

   initial begin
      vec_t vecs[6];
      logic [W-1:0] gq, gr, eq, er;
      logic gdz;
      int lat, busy_bad, unstable, hold;
      logic [W-1:0] a, b;
      int sel;

      vecs[0] = '{a: 30'd100,  b: 30'd7,   q: 30'd14, r: 30'd2,    dz: 1'b0, lat: LAT_N, hold: 0};
      vecs[1] = '{a: 30'd5,    b: 30'd9,   q: 30'd0,  r: 30'd5,    dz: 1'b0, lat: LAT_N, hold: 0};
      vecs[2] = '{a: ONES,     b: 30'd1,   q: ONES,   r: 30'd0,    dz: 1'b0, lat: LAT_N, hold: 0};
      vecs[3] = '{a: ONES,     b: ONES,    q: 30'd1,  r: 30'd0,    dz: 1'b0, lat: LAT_N, hold: 0};
      vecs[4] = '{a: 30'd1000, b: 30'd0,   q: ONES,   r: 30'd1000, dz: DZ_E, lat: LAT_Z, hold: 0};
      vecs[5] = '{a: 30'd77,   b: 30'd3,   q: 30'd25, r: 30'd2,    dz: 1'b0, lat: LAT_N, hold: 5};

      #1;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset div_zero", div_zero, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_job(vecs[i].a, vecs[i].b, vecs[i].hold, gq, gr, gdz, lat, busy_bad, unstable);
         chk($sformatf("vec%0d quotient", i), gq, vecs[i].q);
         chk($sformatf("vec%0d remainder", i), gr, vecs[i].r);
         chk($sformatf("vec%0d div_zero", i), gdz, vecs[i].dz);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d in_ready while busy", i), busy_bad, 0);
         chk($sformatf("vec%0d held outputs unstable", i), unstable, 0);
      end

      // Reset during iteration 10 aborts the job asynchronously.
      @(negedge clk);
      dividend = 30'd200;
      divisor  = 30'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrun reset in_ready", in_ready, 1);
      chk("midrun reset out_valid", out_valid, 0);
      chk("midrun reset quotient", quotient, 0);
      chk("midrun reset remainder", remainder, 0);
      chk("midrun reset div_zero", div_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      run_job(30'd50, 30'd6, 0, gq, gr, gdz, lat, busy_bad, unstable);
      chk("post-reset quotient", gq, 8);
      chk("post-reset remainder", gr, 2);
      chk("post-reset latency", lat, LAT_N);

      for (int n = 0; n < 2000; n++) begin
         a   = W'($urandom);
         sel = $urandom_range(0, 31);
         if (sel == 0)      b = '0;
         else if (sel < 8)  b = W'($urandom_range(1, 255));
         else if (sel < 16) b = W'($urandom_range(1, 65535));
         else               b = W'($urandom);
         hold = ($urandom_range(0, 15) == 0) ? 1 : 0;
         if (b == '0) begin
            eq = ONES;
            er = a;
         end else begin
            eq = a / b;
            er = a % b;
         end
         run_job(a, b, hold, gq, gr, gdz, lat, busy_bad, unstable);
         chk($sformatf("rnd%0d %0d/%0d quotient", n, a, b), gq, eq);
         chk($sformatf("rnd%0d %0d/%0d remainder", n, a, b), gr, er);
         chk($sformatf("rnd%0d latency", n), lat, (b == '0) ? LAT_Z : LAT_N);
         chk($sformatf("rnd%0d div_zero", n), gdz, (b == '0) ? DZ_E : 1'b0);
         if (b != '0) begin
            chk($sformatf("rnd%0d identity", n),
                ((64'(gq) * 64'(b) + 64'(gr)) == 64'(a)) && (gr < b), 1);
         end
         if (busy_bad != 0 || unstable != 0)
            chk($sformatf("rnd%0d handshake violations", n), busy_bad + unstable, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
